// File: rtl/mem_rd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_rd_pkg
//  Purpose  : Shared FSM state type and sizing constants for the memory
//             readback controller and its output FIFO.
//  Revision : 1.0  initial release
// ============================================================================
package mem_rd_pkg;

    localparam int FIFO_DEPTH  = 2;
    localparam int MEM_LATENCY = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_rd_fifo2.sv
`default_nettype none
// ============================================================================
//  Module   : mem_rd_fifo2
//  Purpose  : Two-entry first-word-fall-through FIFO that buffers read data
//             between the memory and the streaming consumer.
//  Revision : 1.0  initial release
// ============================================================================
import mem_rd_pkg::*;

module mem_rd_fifo2 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [1:0]        level
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        cnt_q;
    logic              w_do_pop;
    logic              w_do_push;

    assign empty = (cnt_q == 2'd0);
    assign full  = (cnt_q == 2'(FIFO_DEPTH));
    assign level = cnt_q;
    assign rdata = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (w_do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (w_do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_readback_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_readback_ctrl
//  Purpose  : Reads a burst of words from a 1-cycle-latency memory and streams
//             them out with valid/ready flow control, accumulating a checksum.
//  Revision : 1.0  initial release
// ============================================================================
import mem_rd_pkg::*;

module mem_readback_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W:0] MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

    rd_state_e              state_q;
    logic [ADDR_W-1:0]      base_q;
    logic [ADDR_W:0]        count_q;
    logic [ADDR_W:0]        issued_q;
    logic [MEM_LATENCY-1:0] inflight_q;
    logic [DATA_W-1:0]      checksum_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic [1:0]             w_level;
    logic [1:0]             w_fill;
    logic [ADDR_W:0]        w_count_clamp;
    logic [ADDR_W:0]        w_issued_inc;

    mem_rd_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q[MEM_LATENCY-1]),
        .wdata (mem_rdata),
        .pop   (w_pop),
        .rdata (out_data),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    assign out_valid = ~w_empty;
    assign w_pop     = out_valid & out_ready;

    // A word leaving this cycle frees its slot, so the read pipe can stay
    // full at one word per cycle without ever overrunning the FIFO.
    assign w_fill = w_level + 2'($countones(inflight_q)) - {1'b0, w_pop};
    assign mem_re = (state_q == ST_READ) && (issued_q < count_q)
                    && (w_fill < 2'(FIFO_DEPTH));

    assign mem_addr      = base_q + issued_q[ADDR_W-1:0];
    assign w_issued_inc  = issued_q + ONE;
    assign w_count_clamp = (count > MAX_COUNT) ? MAX_COUNT : count;

    assign busy     = busy_q;
    assign done     = done_q;
    assign checksum = checksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            inflight_q <= '0;
            checksum_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inflight_q <= MEM_LATENCY'({inflight_q, mem_re});
            done_q     <= 1'b0;
            if (w_pop) begin
                checksum_q <= checksum_q + out_data;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_q     <= base_addr;
                        count_q    <= w_count_clamp;
                        issued_q   <= '0;
                        checksum_q <= '0;
                        busy_q     <= 1'b1;
                        if (w_count_clamp == '0) begin
                            state_q <= ST_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (mem_re) begin
                        issued_q <= w_issued_inc;
                        if (w_issued_inc == count_q) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Last word: it is the only one buffered and nothing is still coming back.
                    if (w_pop && !w_full && (inflight_q == '0)) begin
                        state_q <= ST_FINISH;
                        done_q  <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_readback_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_readback_ctrl
//  Purpose  : Self-checking bench for mem_readback_ctrl with a memory model,
//             a burst-level scoreboard and directed burst scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_readback_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  base_addr;
    logic [3:0]  count;
    logic        mem_re;
    logic [2:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    int total = 0;
    int bad   = 0;

    mem_readback_ctrl #(
        .ADDR_W (3),
        .DATA_W (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: word k holds 0x1000_0000 + k, returned one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= 32'h1000_0000 + {29'd0, mem_addr};
        else        mem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Burst-level model: which addresses may be read, which word must come out
    // next, what the checksum is, and when done/busy must show.
    int          exp_base, exp_cnt, n_iss, n_xfer;
    bit          exp_busy, exp_done, nxt_done, was_busy;
    logic [31:0] exp_sum, exp_word;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("sb_rst_outs", {28'd0, mem_re, out_valid, busy, done}, 32'd0);
            chk("sb_rst_sum", checksum, 32'd0);
            exp_busy = 0; exp_done = 0; exp_sum = '0;
            n_iss = 0; n_xfer = 0; exp_cnt = 0; exp_base = 0;
        end else begin
            nxt_done = 0;
            chk("done", done, exp_done);
            chk("busy", busy, exp_busy);
            chk("checksum", checksum, exp_sum);
            if (mem_re) begin
                chk("re_allowed", (exp_busy && n_iss < exp_cnt), 1);
                chk("mem_addr", mem_addr, (exp_base + n_iss) % 8);
                n_iss++;
            end
            if (out_valid && out_ready) begin
                exp_word = 32'h1000_0000 + ((exp_base + n_xfer) % 8);
                if (n_xfer >= exp_cnt) chk("extra_word", n_xfer + 1, exp_cnt);
                else                   chk("out_data", out_data, exp_word);
                exp_sum = exp_sum + exp_word;
                n_xfer++;
                if (n_xfer == exp_cnt) nxt_done = 1;
            end
            chk("outstanding_le2", ((n_iss - n_xfer) <= 2), 1);
            was_busy = exp_busy;
            if (exp_done) exp_busy = 0;
            if (start && !was_busy) begin
                exp_base = int'(base_addr);
                exp_cnt  = (count > 4'd8) ? 8 : int'(count);
                n_iss = 0; n_xfer = 0; exp_sum = '0; exp_busy = 1;
                if (exp_cnt == 0) nxt_done = 1;
            end
            exp_done = nxt_done;
        end
    end

    function automatic logic rdy(input int mode, input int c);
        if (mode == 1) return (c <= 8) ? (c % 2 == 1) : (c > 18);
        return 1'b1;
    endfunction

    // mode 0: ready high; 1: toggle then stall; 2: stray start mid-burst;
    // 3: reset after three transfers.
    task automatic run_burst(input int b, input int n, input int mode,
                             output int fv, output int dc, output int dcnt,
                             output int nre, output logic [11:0] aseq);
        int c, nx;
        fv = 0; dc = 0; dcnt = 0; nre = 0; aseq = '0; c = 0; nx = 0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = b[2:0]; count = n[3:0]; out_ready = rdy(mode, 1);
        while (c < 100 && !(dc != 0 && c >= dc + 1)) begin
            @(negedge clk);
            c++;
            if (mem_re) begin
                if (nre < 4) aseq[nre*3 +: 3] = mem_addr;
                nre++;
            end
            if (out_valid && fv == 0) fv = c;
            if (out_valid && out_ready) nx++;
            if (done) begin
                dcnt++;
                if (dc == 0) dc = c;
            end
            if (mode == 1 && c == 18) chk("stall_mem_re", mem_re, 0);
            if (mode == 3 && nx == 3) begin
                @(posedge clk); #1;
                rst_n = 1'b0; start = 1'b0;
                #1;
                chk("rst_now_ctl", {28'd0, mem_re, out_valid, busy, done}, 32'd0);
                chk("rst_now_addr", mem_addr, 0);
                chk("rst_now_data", out_data, 0);
                chk("rst_now_sum", checksum, 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                @(negedge clk);
                chk("post_rst_valid", out_valid, 0);
                chk("post_rst_busy", busy, 0);
                return;
            end
            @(posedge clk); #1;
            start = (mode == 2 && c + 1 == 4);
            if (start) begin
                base_addr = 3'd0; count = 4'd3;
            end
            out_ready = rdy(mode, c + 1);
        end
        chk("done_seen", (dc != 0), 1);
    endtask

    int          fv, dc, dcnt, nre;
    logic [11:0] aseq;

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_re", mem_re, 0);

        // Full burst, ready held high
        run_burst(0, 8, 0, fv, dc, dcnt, nre, aseq);
        chk("A_first_valid", fv, 4);
        chk("A_done_cycle", dc, 12);
        chk("A_done_len", dcnt, 1);
        chk("A_reads", nre, 8);
        chk("A_sum", checksum, 32'h8000_001C);

        // Wrapping burst
        run_burst(6, 4, 0, fv, dc, dcnt, nre, aseq);
        chk("B_addr_seq", {20'd0, aseq}, 32'h0000_023E);
        chk("B_first_valid", fv, 4);
        chk("B_done_cycle", dc, 8);
        chk("B_reads", nre, 4);
        chk("B_sum", checksum, 32'h4000_000E);

        // Back-pressure
        run_burst(0, 8, 1, fv, dc, dcnt, nre, aseq);
        chk("C_reads", nre, 8);
        chk("C_done_len", dcnt, 1);
        chk("C_sum", checksum, 32'h8000_001C);

        // Zero-length burst
        run_burst(5, 0, 0, fv, dc, dcnt, nre, aseq);
        chk("D_done_cycle", dc, 2);
        chk("D_reads", nre, 0);
        chk("D_valid_never", fv, 0);
        chk("D_sum", checksum, 32'h0);

        // Reset mid-burst, then a clean full burst
        run_burst(0, 8, 3, fv, dc, dcnt, nre, aseq);
        run_burst(0, 8, 0, fv, dc, dcnt, nre, aseq);
        chk("E_done_cycle", dc, 12);
        chk("E_sum", checksum, 32'h8000_001C);

        // Start during a burst is ignored
        run_burst(2, 5, 2, fv, dc, dcnt, nre, aseq);
        chk("F_done_cycle", dc, 9);
        chk("F_reads", nre, 5);
        chk("F_sum", checksum, 32'h5000_0014);

        // Count above the memory size is clamped to 8
        run_burst(3, 12, 0, fv, dc, dcnt, nre, aseq);
        chk("G_reads", nre, 8);
        chk("G_done_cycle", dc, 12);
        chk("G_sum", checksum, 32'h8000_001C);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
